ped_req_conditioner: RTL and testbench
======================================

PED_REQ_CONDITIONER -- requirements
Module: ped_req_conditioner

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 4, giving consecutive stable cycles (1..15) to accept a level change.
REQ-002 SHALL have parameter COOLDOWN_CYCLES, default 8, giving cycles (1..255) after a walk phase during which presses are discarded.
REQ-003 SHALL have parameter EMG_HOLD_CYCLES, default 6, giving cycles (1..255) emergency stays asserted after the debounced input falls.
REQ-004 SHALL have port clk, input, 1 bit: clock, rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port btn_raw, input, 2 bits: asynchronous kerb push-buttons, one per kerb side, active-high.
REQ-007 SHALL have port emg_raw, input, 1 bit: asynchronous emergency-vehicle detector, active-high.
REQ-008 SHALL have port ped_signal, input, 1 bit: WALK indication fed back from the junction controller.
REQ-009 SHALL have port ped_req, output, 1 bit: registered latched pedestrian request to the junction controller.
REQ-010 SHALL have port emergency, output, 1 bit: registered conditioned emergency request to the junction controller.
REQ-011 SHALL have port wait_led, output, 1 bit: "request registered" lamp, equal to ped_req.
REQ-012 SHALL have port req_count, output, 8 bits: saturating count of accepted requests.

Function
REQ-013 SHALL pass each of btn_raw[0], btn_raw[1] and emg_raw through a 2-flop synchronizer, then a debouncer.
REQ-014 Debouncer SHALL flip its level only after the synchronized input differs from the level for DEBOUNCE_CYCLES consecutive cycles; any agreeing cycle SHALL clear its counter.
REQ-015 A press event SHALL be a rising edge of either debounced button level; both buttons rising in the same cycle SHALL count as one press.
REQ-016 FSM SHALL have four states: IDLE, PENDING, SERVING, COOLDOWN.
REQ-017 IDLE -> PENDING SHALL occur on a press event; ped_signal high in IDLE SHALL be ignored.
REQ-018 PENDING -> SERVING SHALL occur when ped_signal = 1; further presses in PENDING SHALL be absorbed.
REQ-019 SERVING -> COOLDOWN SHALL occur when ped_signal = 0, clearing the cooldown counter.
REQ-020 COOLDOWN -> IDLE SHALL occur after exactly COOLDOWN_CYCLES cycles in COOLDOWN; presses in COOLDOWN SHALL be discarded, not queued.
REQ-021 ped_req SHALL be 1 exactly when state = PENDING.
REQ-022 With btn_raw held high, ped_req SHALL rise after rising edge DEBOUNCE_CYCLES+3, counting the first edge sampling btn_raw high as edge 1.
REQ-023 req_count SHALL increment on each IDLE -> PENDING transition and saturate at 255.
REQ-024 emergency SHALL equal the debounced emg level OR (hold counter != 0).
REQ-025 The hold counter SHALL load EMG_HOLD_CYCLES on a debounced emg falling edge, decrement to 0, and clear when debounced emg rises again.
REQ-026 Emergency SHALL NOT alter the request FSM; a pending request SHALL remain pending through emergency.

Reset
REQ-027 On reset, all synchronizer, debouncer and counter registers SHALL be cleared; state SHALL be IDLE; ped_req, emergency, wait_led and req_count SHALL be 0.
REQ-028 Reset asserted mid-request or mid-hold SHALL discard the request or hold with no residual output after release.

Structure
REQ-029 The FSM state encoding and default parameter values SHALL live in the shared package traffic_pkg.
REQ-030 Synchronizer plus debouncer SHALL be one sub-module, sync_debounce, instantiated three times.

Verification
REQ-031 The bench SHALL apply btn_raw[0] high for 3 cycles with defaults and require ped_req to stay 0 and req_count to stay 0.
REQ-032 The bench SHALL hold btn_raw[1] high and require ped_req = 1 after edge 7, req_count = 1, then ped_signal 1 -> ped_req 0 on the next edge.
REQ-033 The bench SHALL drop ped_signal, then apply a 10-cycle press inside 8-cycle COOLDOWN, and require no new request; the same press applied after return to IDLE SHALL set ped_req.
REQ-034 The bench SHALL raise both buttons on the same cycle and require a single request with req_count incremented by exactly 1.
REQ-035 The bench SHALL apply emg_raw high for 10 cycles, then low, and require emergency to stay high for 6 + 4 + 2 cycles after the fall, then drop to 0.
REQ-036 The bench SHALL assert reset while PENDING with hold active and require ped_req = emergency = 0 and req_count = 0 asynchronously.

Source files
------------

// File: rtl/traffic_pkg.sv
// traffic_pkg: shared request-FSM encoding and default timing parameters
package traffic_pkg;
  typedef enum logic [1:0] {IDLE, PENDING, SERVING, COOLDOWN} ped_state_e;
  localparam int DEF_DEBOUNCE_CYCLES = 4;
  localparam int DEF_COOLDOWN_CYCLES = 8;
  localparam int DEF_EMG_HOLD_CYCLES = 6;
endpackage

// File: rtl/sync_debounce.sv
// sync_debounce: 2-flop synchronizer followed by a consecutive-cycle debouncer
module sync_debounce #(
  parameter int DEBOUNCE_CYCLES = traffic_pkg::DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic level_o,
  output logic flip_o
);
  logic sync1_q, sync2_q, level_q, level_d, diff;
  logic [3:0] cnt_q, cnt_d;
  assign diff    = sync2_q != level_q;
  assign flip_o  = diff && cnt_q == 4'(DEBOUNCE_CYCLES - 1);
  assign cnt_d   = (!diff || flip_o) ? 4'd0 : cnt_q + 4'd1;
  assign level_d = flip_o ? ~level_q : level_q;
  assign level_o = level_q;
  // flip_o is high in the cycle before level_o changes, so callers can act on the same edge
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= 4'd0;
      level_q <= 1'b0;
    end else begin
      sync1_q <= d_i;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
endmodule

// File: rtl/ped_req_conditioner.sv
// ped_req_conditioner: conditions kerb buttons into a latched request and stretches the emergency input
module ped_req_conditioner
  import traffic_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int COOLDOWN_CYCLES = DEF_COOLDOWN_CYCLES,
  parameter int EMG_HOLD_CYCLES = DEF_EMG_HOLD_CYCLES
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] btn_raw,
  input  logic       emg_raw,
  input  logic       ped_signal,
  output logic       ped_req,
  output logic       emergency,
  output logic       wait_led,
  output logic [7:0] req_count
);
  logic [1:0] btn_lvl, btn_flip;
  logic       emg_lvl, emg_flip, press_d, press_q;
  logic [7:0] cool_q, cool_d, count_q, count_d, hold_q, hold_d;
  ped_state_e state_q, state_d;
  sync_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn0 (
    .clk(clk), .reset(reset), .d_i(btn_raw[0]), .level_o(btn_lvl[0]), .flip_o(btn_flip[0])
  );
  sync_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn1 (
    .clk(clk), .reset(reset), .d_i(btn_raw[1]), .level_o(btn_lvl[1]), .flip_o(btn_flip[1])
  );
  sync_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_emg (
    .clk(clk), .reset(reset), .d_i(emg_raw), .level_o(emg_lvl), .flip_o(emg_flip)
  );
  assign press_d   = |(btn_flip & ~btn_lvl);
  assign hold_d    = (emg_flip & ~emg_lvl) ? 8'd0 :
                     (emg_flip &  emg_lvl) ? 8'(EMG_HOLD_CYCLES) :
                     hold_q - {7'd0, |hold_q};
  assign ped_req   = state_q == PENDING;
  assign wait_led  = ped_req;
  assign emergency = emg_lvl | (|hold_q);
  assign req_count = count_q;
  // state, counters and the registered press event
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      cool_q  <= 8'd0;
      count_q <= 8'd0;
      hold_q  <= 8'd0;
      press_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cool_q  <= cool_d;
      count_q <= count_d;
      hold_q  <= hold_d;
      press_q <= press_d;
    end
  // request FSM: presses outside IDLE are dropped, never queued
  always_comb begin
    state_d = state_q;
    cool_d  = cool_q;
    count_d = count_q;
    case (state_q)
      IDLE: if (press_q) begin
        state_d = PENDING;
        count_d = (count_q == 8'hFF) ? count_q : count_q + 8'd1;
      end
      PENDING: if (ped_signal) state_d = SERVING;
      SERVING: if (!ped_signal) begin
        state_d = COOLDOWN;
        cool_d  = 8'd0;
      end
      COOLDOWN: begin
        cool_d  = cool_q + 8'd1;
        state_d = (cool_q == 8'(COOLDOWN_CYCLES - 1)) ? IDLE : COOLDOWN;
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_ped_req_conditioner.sv
// tb_ped_req_conditioner: directed checks of request latching, cooldown, emergency hold and reset
module tb_ped_req_conditioner;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] btn_raw = 2'b00;
  logic       emg_raw = 1'b0;
  logic       ped_signal = 1'b0;
  logic       ped_req, emergency, wait_led;
  logic [7:0] req_count;
  int n_chk = 0;
  int n_pass = 0;
  ped_req_conditioner dut (
    .clk(clk), .reset(reset), .btn_raw(btn_raw), .emg_raw(emg_raw), .ped_signal(ped_signal),
    .ped_req(ped_req), .emergency(emergency), .wait_led(wait_led), .req_count(req_count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    else n_pass++;
  endtask
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  initial begin
    step(2);
    chk("rst_req", ped_req, 0);
    chk("rst_emg", emergency, 0);
    chk("rst_led", wait_led, 0);
    chk("rst_cnt", req_count, 0);
    reset = 1'b0;
    step(2);
    btn_raw = 2'b01;
    step(3);
    btn_raw = 2'b00;
    chk("short_req", ped_req, 0);
    step(10);
    chk("short_req2", ped_req, 0);
    chk("short_cnt", req_count, 0);
    btn_raw = 2'b10;
    step(6);
    chk("b1_edge6", ped_req, 0);
    step(1);
    chk("b1_edge7", ped_req, 1);
    chk("b1_led", wait_led, 1);
    chk("b1_cnt", req_count, 1);
    ped_signal = 1'b1;
    step(1);
    chk("serve_req", ped_req, 0);
    btn_raw = 2'b00;
    step(8);
    ped_signal = 1'b0;
    btn_raw = 2'b01;
    step(10);
    btn_raw = 2'b00;
    chk("cool_req", ped_req, 0);
    step(12);
    chk("cool_req2", ped_req, 0);
    chk("cool_cnt", req_count, 1);
    btn_raw = 2'b01;
    step(7);
    chk("idle_req", ped_req, 1);
    chk("idle_cnt", req_count, 2);
    btn_raw = 2'b00;
    ped_signal = 1'b1;
    step(1);
    ped_signal = 1'b0;
    step(12);
    chk("back_idle", ped_req, 0);
    btn_raw = 2'b11;
    step(6);
    chk("both_e6", ped_req, 0);
    step(1);
    chk("both_req", ped_req, 1);
    chk("both_cnt", req_count, 3);
    btn_raw = 2'b00;
    step(10);
    chk("both_cnt2", req_count, 3);
    emg_raw = 1'b1;
    step(5);
    chk("emg_e5", emergency, 0);
    step(1);
    chk("emg_e6", emergency, 1);
    step(4);
    emg_raw = 1'b0;
    step(5);
    chk("hold_e5", emergency, 1);
    step(6);
    chk("hold_e11", emergency, 1);
    step(1);
    chk("hold_e12", emergency, 0);
    chk("emg_pend", ped_req, 1);
    chk("emg_cnt", req_count, 3);
    emg_raw = 1'b1;
    step(10);
    emg_raw = 1'b0;
    step(8);
    chk("pre_rst_emg", emergency, 1);
    chk("pre_rst_req", ped_req, 1);
    #2 reset = 1'b1;
    #1;
    chk("arst_req", ped_req, 0);
    chk("arst_emg", emergency, 0);
    chk("arst_cnt", req_count, 0);
    step(2);
    reset = 1'b0;
    step(15);
    chk("post_req", ped_req, 0);
    chk("post_emg", emergency, 0);
    chk("post_cnt", req_count, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
